// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared types and width helpers for the tiled block loader
package load_pkg;

  // Tag coordinates are sized to the 8-bit tile origin ports, which bounds TR and TC.
  localparam int IDX_W = 8;

  typedef struct packed {
    logic             valid;
    logic             oob;
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] c;
  } rd_tag_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } load_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - DEPTH-stage shift register carrying read tags alongside RAM latency
module rd_tag_pipe
  import load_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag,
  output logic    o_busy
);

  rd_tag_t r_stage [0:DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) o_busy = o_busy | r_stage[k].valid;
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/load_block_tiled.sv
// rtl/load_block_tiled.sv - fetches a TR x TC tile from a row-major RAM into a register array
// Element 0 is issued on the start edge itself; the issue tag register plus RD_LAT pipe stages line each tag up with its RAM data.
module load_block_tiled
  import load_pkg::*;
#(
  parameter int DW     = 16,
  parameter int TR     = 4,
  parameter int TC     = 4,
  parameter int M_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int RD_LAT = 1,
  parameter int AW     = $clog2(M_ROWS * N_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    block_row,
  input  logic [7:0]    block_col,
  input  logic          transpose,
  output logic          rd_en,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] block_mat [0:TR-1][0:TC-1],
  output logic          busy,
  output logic          done
);

  localparam int   RW       = cnt_w(TR);
  localparam int   CW       = cnt_w(TC);
  localparam logic TR_EQ_TC = (TR == TC);

  load_state_e r_state, w_state_nxt;

  logic [7:0]    r_row, r_col;
  logic          r_xpose;
  logic [RW-1:0] r_r;
  logic [CW-1:0] r_c;
  rd_tag_t       r_iss_tag;

  logic          w_accept, w_issue, w_last, w_done, w_inb, w_pipe_busy;
  logic [7:0]    w_row, w_col;
  logic [RW-1:0] w_r, w_r_nxt;
  logic [CW-1:0] w_c, w_c_nxt;
  logic [8:0]    w_gr, w_gc;
  logic [AW-1:0] w_lin;
  logic [IDX_W-1:0] w_dst_r, w_dst_c;
  rd_tag_t       w_out_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_row       = r_row;
    w_col       = r_col;
    w_r         = r_r;
    w_c         = r_c;
    case (r_state)
      S_IDLE:  w_accept = start;
      S_ISSUE: w_issue  = 1'b1;
      S_DRAIN: begin
        if (!r_iss_tag.valid && !w_pipe_busy) begin
          w_done      = 1'b1;
          w_accept    = start;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new request issues its first element straight from the input ports.
    if (w_accept) begin
      w_issue     = 1'b1;
      w_row       = block_row;
      w_col       = block_col;
      w_r         = '0;
      w_c         = '0;
      w_state_nxt = S_ISSUE;
    end
    w_last = (w_r == RW'(TR - 1)) && (w_c == CW'(TC - 1));
    if (w_issue && w_last) w_state_nxt = S_DRAIN;
    if (w_c == CW'(TC - 1)) begin
      w_c_nxt = '0;
      w_r_nxt = w_r + RW'(1);
    end else begin
      w_c_nxt = w_c + CW'(1);
      w_r_nxt = w_r;
    end
  end

  assign w_gr  = {1'b0, w_row} + 9'(w_r);
  assign w_gc  = {1'b0, w_col} + 9'(w_c);
  assign w_inb = (int'(w_gr) < M_ROWS) && (int'(w_gc) < N_COLS);
  assign w_lin = AW'(int'(w_gr) * N_COLS + int'(w_gc));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row     <= '0;
      r_col     <= '0;
      r_xpose   <= 1'b0;
      r_r       <= '0;
      r_c       <= '0;
      rd_en     <= 1'b0;
      addr      <= '0;
      r_iss_tag <= '0;
    end else begin
      if (w_accept) begin
        r_row   <= block_row;
        r_col   <= block_col;
        r_xpose <= transpose & TR_EQ_TC;
      end
      if (w_issue) begin
        r_r <= w_r_nxt;
        r_c <= w_c_nxt;
      end
      rd_en <= w_issue & w_inb;
      if (w_issue && w_inb) addr <= w_lin;
      r_iss_tag <= '{valid: w_issue, oob: !w_inb, r: IDX_W'(w_r), c: IDX_W'(w_c)};
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_tag  (r_iss_tag),
    .o_tag  (w_out_tag),
    .o_busy (w_pipe_busy)
  );

  // The pipe is empty whenever a new load is accepted, so the live transpose flag is safe here.
  assign w_dst_r = r_xpose ? w_out_tag.c : w_out_tag.r;
  assign w_dst_c = r_xpose ? w_out_tag.r : w_out_tag.c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TR; i++)
        for (int j = 0; j < TC; j++)
          block_mat[i][j] <= '0;
    end else if (w_out_tag.valid) begin
      for (int i = 0; i < TR; i++)
        for (int j = 0; j < TC; j++)
          if (w_dst_r == IDX_W'(i) && w_dst_c == IDX_W'(j))
            block_mat[i][j] <= w_out_tag.oob ? '0 : din;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = w_done;

  a_xpose_square : assert property (@(posedge clk) disable iff (rst)
    !(w_accept && transpose && !TR_EQ_TC));

endmodule

// File: tb/tb_load_block_tiled.sv
// tb/tb_load_block_tiled.sv - directed checks of load_block_tiled at read latencies 1 and 3
`timescale 1ns/1ps
module tb_load_block_tiled;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       transpose = 1'b0;
  logic [7:0] block_row = 8'd0;
  logic [7:0] block_col = 8'd0;

  logic        rd_en1, rd_en3, busy1, busy3, done1, done3;
  logic [7:0]  addr1, addr3;
  logic [15:0] din1, din3;
  logic [15:0] mat1 [0:3][0:3];
  logic [15:0] mat3 [0:3][0:3];
  logic [7:0]  q1;
  logic [7:0]  q3 [0:2];

  int n_vec = 0;
  int n_err = 0;

  int n_rd1, n_rd3, first1, last1, first3, last3, done1_at, done3_at;
  int busy1_post, b2b_rd, b2b_addr;
  int aq[$];

  always #5 clk = ~clk;

  load_block_tiled #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .block_row(block_row), .block_col(block_col),
    .transpose(transpose), .rd_en(rd_en1), .addr(addr1), .din(din1),
    .block_mat(mat1), .busy(busy1), .done(done1)
  );

  load_block_tiled #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .block_row(block_row), .block_col(block_col),
    .transpose(transpose), .rd_en(rd_en3), .addr(addr3), .din(din3),
    .block_mat(mat3), .busy(busy3), .done(done3)
  );

  // RAM models: word value equals its address, data out RD_LAT cycles after rd_en.
  always @(posedge clk) begin
    if (rd_en1) q1 <= addr1;
    if (rd_en3) q3[0] <= addr3;
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign din1 = {8'h00, q1};
  assign din3 = {8'h00, q3[2]};

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_ent(input int row, input int col, input bit xp, input int i, input int j);
    int gr;
    int gc;
    gr = row + (xp ? j : i);
    gc = col + (xp ? i : j);
    return (gr < 16 && gc < 16) ? gr * 16 + gc : 0;
  endfunction

  function automatic int aq_at(input int i);
    return (i < aq.size()) ? aq[i] : -1;
  endfunction

  task automatic chk_mat(input string tag, input int row, input int col, input bit xp, input bit both);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("%s_lat1[%0d][%0d]", tag, i, j), int'(mat1[i][j]), exp_ent(row, col, xp, i, j));
        if (both)
          chk($sformatf("%s_lat3[%0d][%0d]", tag, i, j), int'(mat3[i][j]), exp_ent(row, col, xp, i, j));
      end
  endtask

  task automatic do_load(input int row, input int col, input bit xp, input bit poke,
                         input bit chain, input int crow, input int ccol);
    @(negedge clk);
    block_row = 8'(row);
    block_col = 8'(col);
    transpose = xp;
    start     = 1'b1;
    @(posedge clk);
    n_rd1 = 0; n_rd3 = 0; first1 = -1; last1 = -1; first3 = -1; last3 = -1;
    done1_at = -1; done3_at = -1; busy1_post = -1; b2b_rd = -1; b2b_addr = -1;
    aq.delete();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en1) begin
        n_rd1++;
        aq.push_back(int'(addr1));
        if (first1 < 0) first1 = k;
        last1 = k;
      end
      if (rd_en3) begin
        n_rd3++;
        if (first3 < 0) first3 = k;
        last3 = k;
      end
      if (done1 && done1_at < 0) begin
        done1_at = k;
        if (chain) begin
          start     = 1'b1;
          block_row = 8'(crow);
          block_col = 8'(ccol);
          transpose = 1'b0;
        end
      end else if (done1_at > 0 && k == done1_at + 1) begin
        busy1_post = int'(busy1);
        b2b_rd     = int'(rd_en1);
        b2b_addr   = int'(addr1);
      end
      if (done3 && done3_at < 0) done3_at = k;
      if (poke && k == 5) begin
        start     = 1'b1;
        block_row = 8'd0;
        block_col = 8'd0;
        transpose = !xp;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_rd_en", int'(rd_en1), 0);
    chk("rst_addr", int'(addr1), 0);
    chk("rst_mat", int'(mat1[2][3]), 0);
    rst = 1'b0;

    // In-bounds tile at (4,8)
    do_load(4, 8, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("t1_nrd", n_rd1, 16);
    chk("t1_first_rd", first1, 1);
    chk("t1_span", last1 - first1 + 1, 16);
    chk("t1_addr0", aq_at(0), 72);
    chk("t1_addr3", aq_at(3), 75);
    chk("t1_addr4", aq_at(4), 88);
    chk("t1_addr15", aq_at(15), 123);
    chk("t1_m12", int'(mat1[1][2]), 90);
    chk("t1_done_lat", done1_at, 18);
    chk("t1_busy_post", busy1_post, 0);
    chk("t1_lat3_done", done3_at, 20);
    chk("t1_lat3_nrd", n_rd3, 16);
    chk("t1_lat3_span", last3 - first3 + 1, 16);
    chk("t1_lat3_m12", int'(mat3[1][2]), 90);
    chk_mat("t1", 4, 8, 1'b0, 1'b1);

    // Bottom-right overhang
    do_load(14, 14, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("t2_nrd", n_rd1, 4);
    chk("t2_addr0", aq_at(0), 238);
    chk("t2_addr1", aq_at(1), 239);
    chk("t2_addr2", aq_at(2), 254);
    chk("t2_addr3", aq_at(3), 255);
    chk("t2_m00", int'(mat1[0][0]), 238);
    chk("t2_m11", int'(mat1[1][1]), 255);
    chk("t2_m23", int'(mat1[2][3]), 0);
    chk("t2_done_lat", done1_at, 18);
    chk("t2_lat3_done", done3_at, 20);
    chk_mat("t2", 14, 14, 1'b0, 1'b1);

    // Transpose on load
    do_load(0, 4, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("t3_m30", int'(mat1[3][0]), 7);
    chk("t3_m03", int'(mat1[0][3]), 52);
    chk("t3_m21", int'(mat1[2][1]), 22);
    chk("t3_lat3_m30", int'(mat3[3][0]), 7);
    chk_mat("t3", 0, 4, 1'b1, 1'b1);

    // Start while busy is ignored
    do_load(8, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    chk("t4_nrd", n_rd1, 16);
    chk("t4_done_lat", done1_at, 18);
    chk("t4_m11", int'(mat1[1][1]), 145);
    chk("t4_lat3_nrd", n_rd3, 16);
    chk_mat("t4", 8, 0, 1'b0, 1'b1);

    // Start on the done cycle chains a second load
    do_load(0, 0, 1'b0, 1'b0, 1'b1, 12, 12);
    chk("t5_done_lat", done1_at, 18);
    chk("t5_b2b_rd", b2b_rd, 1);
    chk("t5_b2b_addr", b2b_addr, 204);
    chk("t5_b2b_busy", busy1_post, 1);
    chk("t5_nrd", n_rd1, 32);
    chk("t5_m00", int'(mat1[0][0]), 204);
    chk("t5_m33", int'(mat1[3][3]), 255);
    chk_mat("t5", 12, 12, 1'b0, 1'b0);

    // Reset in the middle of a load
    @(negedge clk);
    block_row = 8'd4;
    block_col = 8'd8;
    transpose = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_pre_rd_en", int'(rd_en1), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_busy", int'(busy1), 0);
    chk("t6_rd_en", int'(rd_en1), 0);
    chk("t6_done", int'(done1), 0);
    chk("t6_m00", int'(mat1[0][0]), 0);
    chk("t6_m33", int'(mat1[3][3]), 0);
    chk("t6_lat3_busy", int'(busy3), 0);
    @(negedge clk);
    rst = 1'b0;
    do_load(2, 2, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("t6_m22", int'(mat1[2][2]), 68);
    chk("t6_done_lat", done1_at, 18);
    chk_mat("t6", 2, 2, 1'b0, 1'b1);

    // Tile entirely outside the matrix
    do_load(16, 20, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("t7_nrd", n_rd1, 0);
    chk("t7_lat3_nrd", n_rd3, 0);
    chk("t7_done_lat", done1_at, 18);
    chk("t7_lat3_done", done3_at, 20);
    chk_mat("t7", 16, 20, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
